seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter: the source end of the serial bit-stream interface consumed by the team's Moore sequence detectors.
Shifts a programmable pattern (e.g. 110) out MSB-first, one bit per clock, for a programmed number of repetitions, with optional idle gaps between repetitions.
Drives detector din in block-level benches and feeds on-chip self-test.
Registered outputs throughout; single clock domain.

Parameters:
MAX_W, 8, maximum pattern length in bits; pattern port width.
LEN_W, 4, width of pat_len; must hold MAX_W.
CNT_W, 8, width of repetition count and repetition counter.
GAP_CYC, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
abort  in  1  terminate the current transfer.
pattern  in  MAX_W  pattern bits; bit pat_len-1 is sent first.
pat_len  in  LEN_W  pattern length, legal range 1..MAX_W.
rep_cnt  in  CNT_W  number of repetitions; 0 = continuous until abort.
dout  out  1  serial data bit.
dout_vld  out  1  dout carries a pattern bit this cycle.
busy  out  1  transfer in progress (any state except IDLE).
done  out  1  one-cycle pulse after the last bit of the last repetition.
err  out  1  one-cycle pulse when start is rejected for an illegal pat_len.

Behaviour:
- Reset (rst=0, async): state=IDLE; dout=0, dout_vld=0, busy=0, done=0, err=0; all counters and shadow registers cleared.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 with 1<=pat_len<=MAX_W: latch pattern, pat_len and rep_cnt into shadow registers; bit index = pat_len-1; repetitions remaining = rep_cnt; go to SHIFT.
  - First bit is on dout with dout_vld=1 in the cycle after the start edge (latency 1).
  - start=1 with pat_len=0 or pat_len>MAX_W: err=1 for one cycle; stay in IDLE.
- Port changes after start are ignored until the next IDLE.
- start while busy=1 is ignored; no err pulse.
- SHIFT:
  - Each cycle: dout = shadow[bit index], dout_vld=1, then the index decrements.
  - At index 0 the repetition ends. For finite rep_cnt the remaining count decrements.
  - If repetitions remain, or the mode is continuous: go to GAP when GAP_CYC>0; otherwise wrap the index to pat_len-1 and stay in SHIFT with no bubble.
  - Otherwise: go to IDLE; done=1 in the cycle after the last valid bit, with dout_vld=0 in that cycle.
- GAP: dout=0, dout_vld=0, busy=1 for exactly GAP_CYC cycles, then SHIFT from index pat_len-1.
- Total valid bits for finite rep_cnt = pat_len*rep_cnt.
- Whenever dout_vld=0, dout=0.
- abort=1 in SHIFT or GAP: at the next edge go to IDLE; dout_vld=0, busy=0; no done pulse.
- abort has priority over a simultaneous last bit.
- abort in IDLE has no effect. start and abort together in IDLE: abort wins; start is ignored.
- Counter rules:
  - The index counter is LEN_W bits and never underflows; it reloads at index 0.
  - The repetition counter saturates at 0 and is not decremented in continuous mode.
- Asserting rst mid-transfer ends it immediately; no done pulse.

Optional Feature:
Macro SEQ_GEN_PARITY_EN.
- Defined: after bit 0 of every repetition, one extra cycle in SHIFT sends the even-parity bit over the pat_len pattern bits, with dout_vld=1. GAP and done follow this bit. Valid bits per repetition = pat_len+1.
- Undefined: no parity bit, and no parity logic is synthesized.

Test Plan:
- Reset mid-SHIFT (rst low at the 2nd bit): all outputs 0 immediately; after release, start with pattern=8'b0000_0110, pat_len=3, rep_cnt=1 -> dout 1,1,0 with dout_vld=1 on cycles 1-3 after start; done pulse on cycle 4.
- pattern=0x06, pat_len=3, rep_cnt=2, GAP_CYC=0 -> dout 1,1,0,1,1,0 over 6 consecutive valid cycles; done on cycle 7; the stream drives the 110 detector, which must report two detections.
- GAP_CYC=2, pattern=0x05, pat_len=3, rep_cnt=2 -> 1,0,1, two cycles with dout_vld=0 and dout=0, then 1,0,1; busy=1 throughout; done after the 6th valid bit.
- pat_len=0, then pat_len=9 with start -> err pulse each time, busy stays 0. Start asserted while busy -> no effect on the stream.
- rep_cnt=0 (continuous), pattern=0x03, pat_len=2 -> 1,1,1,1,... beyond 20 cycles; abort on an arbitrary cycle -> dout_vld=0 and busy=0 at the next edge, no done pulse.
- SEQ_GEN_PARITY_EN defined, pattern=0x06, pat_len=3, rep_cnt=1 -> dout 1,1,0,0 (parity 0), 4 valid cycles; done on cycle 5.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, one bit
// per clock, for rep_cnt repetitions (0 = continuous), with GAP_CYC idle cycles
// between repetitions. All outputs are registered.
// Optional build macro SEQ_GEN_PARITY_EN appends an even-parity bit after
// every repetition.
module seq_pattern_gen #(
    parameter int unsigned MAX_W   = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [MAX_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep_cnt,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned      GapW    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
    localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_W);
    localparam logic [GapW-1:0]  GapLoad = GapW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e             state_q;
    logic [MAX_W-1:0]   shadow_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [CNT_W-1:0]   rep_q;
    logic               cont_q;
    logic [GapW-1:0]    gap_q;

    logic               len_ok;
    logic               more_reps;
    logic [MAX_W-1:0]   load_bits;

    // Select one bit of a pattern vector by a LEN_W-wide index.
    function automatic logic pick(input logic [MAX_W-1:0] v, input logic [LEN_W-1:0] i);
        return |(v & (MAX_W'(1) << i));
    endfunction

    assign len_ok    = (pat_len != '0) && (pat_len <= MaxLen);
    // rep_q holds the repetitions still owed including the one now ending.
    assign more_reps = cont_q || (rep_q > CNT_W'(1));

`ifdef SEQ_GEN_PARITY_EN
    logic               par_q;
    logic [MAX_W-1:0]   len_mask;

    // Mask bits above pat_len so the parity reduction covers only sent bits.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            len_mask[i] = (i < int'(pat_len));
        end
    end

    assign load_bits = pattern & len_mask;
`else
    assign load_bits = pattern;
`endif

    // Control FSM with registered outputs; dout always shows the bit at idx_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            cont_q   <= 1'b0;
            gap_q    <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // abort in the same cycle suppresses start entirely
                    if (start && !abort) begin
                        if (len_ok) begin
                            shadow_q <= load_bits;
                            len_q    <= pat_len;
                            rep_q    <= rep_cnt;
                            cont_q   <= (rep_cnt == '0);
                            idx_q    <= pat_len - 1'b1;
                            dout     <= pick(pattern, pat_len - 1'b1);
                            dout_vld <= 1'b1;
                            busy     <= 1'b1;
                            state_q  <= StShift;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        dout     <= 1'b0;
                        dout_vld <= 1'b0;
                        busy     <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
                        par_q    <= 1'b0;
`endif
                    end else if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                        dout  <= pick(shadow_q, idx_q - 1'b1);
                    end
`ifdef SEQ_GEN_PARITY_EN
                    else if (!par_q) begin
                        par_q <= 1'b1;
                        dout  <= ^shadow_q;
                    end
`endif
                    else begin
`ifdef SEQ_GEN_PARITY_EN
                        par_q <= 1'b0;
`endif
                        if (!cont_q && (rep_q != '0)) begin
                            rep_q <= rep_q - 1'b1;
                        end
                        if (more_reps) begin
                            if (GAP_CYC > 0) begin
                                state_q  <= StGap;
                                gap_q    <= GapLoad;
                                dout     <= 1'b0;
                                dout_vld <= 1'b0;
                            end else begin
                                idx_q <= len_q - 1'b1;
                                dout  <= pick(shadow_q, len_q - 1'b1);
                            end
                        end else begin
                            state_q  <= StIdle;
                            dout     <= 1'b0;
                            dout_vld <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        busy     <= 1'b0;
                    end else if (gap_q == '0) begin
                        state_q  <= StShift;
                        idx_q    <= len_q - 1'b1;
                        dout     <= pick(shadow_q, len_q - 1'b1);
                        dout_vld <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: one instance with back-to-back
// repetitions and one with two idle cycles between repetitions. A reference
// model fills a per-cycle scoreboard of {busy,done,vld,dout,err}.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, abort0, start2, abort2;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [7:0] rep_cnt;
    logic       dout0, vld0, busy0, done0, err0;
    logic       dout2, vld2, busy2, done2, err2;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_q[$];
    int         det_cnt;
    logic [2:0] det_sh;

    always #5 clk = ~clk;

    seq_pattern_gen #(.MAX_W(8), .LEN_W(4), .CNT_W(8), .GAP_CYC(0)) u_gen0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .pattern(pattern), .pat_len(pat_len), .rep_cnt(rep_cnt),
        .dout(dout0), .dout_vld(vld0), .busy(busy0), .done(done0), .err(err0)
    );

    seq_pattern_gen #(.MAX_W(8), .LEN_W(4), .CNT_W(8), .GAP_CYC(2)) u_gen2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .pattern(pattern), .pat_len(pat_len), .rep_cnt(rep_cnt),
        .dout(dout2), .dout_vld(vld2), .busy(busy2), .done(done2), .err(err2)
    );

    function automatic logic [4:0] mk(input bit b, input bit d, input bit v, input bit o,
                                      input bit e);
        return {b, d, v, o, e};
    endfunction

    function automatic logic [4:0] obs_of(input int sel);
        return (sel == 0) ? {busy0, done0, vld0, dout0, err0} : {busy2, done2, vld2, dout2, err2};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: {busy,done,vld,dout,err} observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v; else start2 = v;
    endtask

    task automatic set_abort(input int sel, input logic v);
        if (sel == 0) abort0 = v; else abort2 = v;
    endtask

    // Reference model: expected outputs for every cycle after the start edge.
    task automatic build(input logic [7:0] pat, input int len, input int rep, input int gap,
                         input int abort_at);
        int   n;
        int   r;
        logic par;
        n = 0;
        r = 0;
        exp_q.delete();
        forever begin
            par = 1'b0;
            for (int i = len - 1; i >= 0; i--) begin
                exp_q.push_back(mk(1, 0, 1, pat[i], 0));
                par ^= pat[i];
                n++;
                if (abort_at > 0 && n == abort_at) begin
                    exp_q.push_back(5'b0);
                    exp_q.push_back(5'b0);
                    return;
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            exp_q.push_back(mk(1, 0, 1, par, 0));
            n++;
            if (abort_at > 0 && n == abort_at) begin
                exp_q.push_back(5'b0);
                exp_q.push_back(5'b0);
                return;
            end
`endif
            r++;
            if (rep != 0 && r == rep) begin
                exp_q.push_back(mk(0, 1, 0, 0, 0));
                return;
            end
            for (int g = 0; g < gap; g++) exp_q.push_back(mk(1, 0, 0, 0, 0));
        end
    endtask

    // Start one transfer and compare every cycle against the scoreboard.
    task automatic run_xfer(input string tag, input int sel, input logic [7:0] pat,
                            input logic [3:0] len, input logic [7:0] rep, input int abort_at,
                            input int poke_at, input int rst_at);
        int         c;
        logic [4:0] e;
        logic [4:0] o;
        build(pat, int'(len), int'(rep), (sel == 0) ? 0 : 2, abort_at);
        pattern = pat;
        pat_len = len;
        rep_cnt = rep;
        det_cnt = 0;
        det_sh  = 3'b0;
        set_start(sel, 1'b1);
        @(negedge clk);
        c = 1;
        while (exp_q.size() > 0) begin
            set_start(sel, 1'b0);
            set_abort(sel, 1'b0);
            pattern = pat;
            pat_len = len;
            e = exp_q.pop_front();
            o = obs_of(sel);
            check($sformatf("%s cyc%0d", tag, c), o, e);
            if (o[2]) begin
                det_sh = {det_sh[1:0], o[1]};
                if (det_sh == 3'b110) det_cnt++;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                check($sformatf("%s async_rst u0", tag), obs_of(0), 5'b0);
                check($sformatf("%s async_rst u2", tag), obs_of(1), 5'b0);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b1;
            end else begin
                if (c == poke_at) begin
                    set_start(sel, 1'b1);
                    pattern = ~pat;
                    pat_len = 4'd5;
                end
                if (c == abort_at) set_abort(sel, 1'b1);
                @(negedge clk);
            end
            c++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        start0  = 1'b0;
        abort0  = 1'b0;
        start2  = 1'b0;
        abort2  = 1'b0;
        pattern = 8'h00;
        pat_len = 4'd0;
        rep_cnt = 8'd0;
        #1;
        check("reset u0", obs_of(0), 5'b0);
        check("reset u2", obs_of(1), 5'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_xfer("rst_mid", 0, 8'h06, 4'd3, 8'd1, 0, 0, 2);
        run_xfer("one_rep", 0, 8'h06, 4'd3, 8'd1, 0, 0, 0);
        run_xfer("two_rep", 0, 8'h06, 4'd3, 8'd2, 0, 0, 0);
        check_int("det110 count", det_cnt, 2);
        run_xfer("gap2", 1, 8'h05, 4'd3, 8'd2, 0, 0, 0);

        pattern = 8'h06;
        pat_len = 4'd0;
        start0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("err len0", obs_of(0), mk(0, 0, 0, 0, 1));
        @(negedge clk);
        check("err len0 clear", obs_of(0), 5'b0);
        pat_len = 4'd9;
        start0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("err len9", obs_of(0), mk(0, 0, 0, 0, 1));
        @(negedge clk);
        check("err len9 clear", obs_of(0), 5'b0);

        run_xfer("busy_start", 0, 8'h06, 4'd3, 8'd2, 0, 2, 0);
        run_xfer("cont_abort", 0, 8'h03, 4'd2, 8'd0, 25, 0, 0);
        run_xfer("abort_last", 0, 8'h06, 4'd3, 8'd1, 3, 0, 0);

        pattern = 8'h06;
        pat_len = 4'd3;
        rep_cnt = 8'd1;
        start0  = 1'b1;
        abort0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        check("start_abort idle", obs_of(0), 5'b0);
        @(negedge clk);

        run_xfer("full_len", 0, 8'hB4, 4'd8, 8'd1, 0, 0, 0);
        run_xfer("len1_gap", 1, 8'h01, 4'd1, 8'd3, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
